// File: rtl/axi_wr_slave_mem.sv
// Single-beat AXI write slave backed by a byte-strobed 64-bit word array.
// AW and W are buffered independently; the write commits LATENCY cycles after both arrive.
module axi_wr_slave_mem #(
    parameter logic [31:0] BASE    = 32'h8000_0000,
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 2
) (
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic        AWVALID,
    output logic        AWREADY,
    input  logic [31:0] AWADDR,
    input  logic        WVALID,
    output logic        WREADY,
    input  logic [63:0] WDATA,
    input  logic [7:0]  WSTRB,
    input  logic        WLAST,
    output logic        BVALID,
    input  logic        BREADY,
    output logic [1:0]  BRESP,
    input  logic [31:0] dbg_addr,
    output logic [63:0] dbg_rdata
);

    localparam int unsigned IDX_W      = $clog2(DEPTH);
    localparam logic [32:0] SPAN_BYTES = 33'(DEPTH * 8);
    localparam logic [3:0]  LAT_INIT   = 4'(LATENCY);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GOT_AW = 3'd1,
        ST_GOT_W  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

    // 33-bit offset so addresses near the top of the space cannot wrap into range
    function automatic logic addr_in_range(input logic [31:0] a);
        logic [32:0] off;
        off = {1'b0, a} - {1'b0, BASE};
        addr_in_range = (a >= BASE) && (off < SPAN_BYTES);
    endfunction

    function automatic logic [IDX_W-1:0] addr_index(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        addr_index = IDX_W'(off >> 3);
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [63:0] data_q, data_d;
    logic [7:0]  strb_q, strb_d;
    logic        last_q, last_d;
    logic [1:0]  bresp_q, bresp_d;
    logic        commit_s;
    logic        wr_en_s;
    logic        aw_hs_s;
    logic        w_hs_s;
    logic [1:0]  resp_s;
    logic [63:0] mem_q [DEPTH];

    assign AWREADY = !ARESET && ((state_q == ST_IDLE) || (state_q == ST_GOT_W));
    assign WREADY  = !ARESET && ((state_q == ST_IDLE) || (state_q == ST_GOT_AW));
    assign BVALID  = !ARESET && (state_q == ST_RESP);
    assign BRESP   = ARESET ? 2'b00 : bresp_q;

    assign aw_hs_s = AWVALID && AWREADY;
    assign w_hs_s  = WVALID && WREADY;
    assign resp_s  = !addr_in_range(addr_q) ? 2'b11 : (!last_q ? 2'b10 : 2'b00);
    assign wr_en_s = commit_s && (resp_s == 2'b00);

    assign dbg_rdata = addr_in_range(dbg_addr) ? mem_q[addr_index(dbg_addr)] : 64'd0;

    // Next-state, channel latches and commit strobe
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        data_d   = data_q;
        strb_d   = strb_q;
        last_d   = last_q;
        bresp_d  = bresp_q;
        commit_s = 1'b0;

        if (aw_hs_s) begin
            addr_d = AWADDR;
        end else begin
            addr_d = addr_q;
        end
        if (w_hs_s) begin
            data_d = WDATA;
            strb_d = WSTRB;
            last_d = WLAST;
        end else begin
            data_d = data_q;
            strb_d = strb_q;
            last_d = last_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (aw_hs_s && w_hs_s) begin
                    state_d = ST_WAIT;
                    cnt_d   = LAT_INIT;
                end else if (aw_hs_s) begin
                    state_d = ST_GOT_AW;
                end else if (w_hs_s) begin
                    state_d = ST_GOT_W;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GOT_AW: begin
                if (w_hs_s) begin
                    state_d = ST_WAIT;
                    cnt_d   = LAT_INIT;
                end else begin
                    state_d = ST_GOT_AW;
                end
            end
            ST_GOT_W: begin
                if (aw_hs_s) begin
                    state_d = ST_WAIT;
                    cnt_d   = LAT_INIT;
                end else begin
                    state_d = ST_GOT_W;
                end
            end
            ST_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    commit_s = 1'b1;
                    bresp_d  = resp_s;
                    state_d  = ST_RESP;
                end
            end
            ST_RESP: begin
                if (BREADY) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control state and latches; reset drops any pending write
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            data_q  <= 64'd0;
            strb_q  <= 8'd0;
            last_q  <= 1'b0;
            bresp_q <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            strb_q  <= strb_d;
            last_q  <= last_d;
            bresp_q <= bresp_d;
        end
    end

    // Word array is deliberately not cleared by reset
    always_ff @(posedge ACLK) begin
        if (!ARESET && wr_en_s) begin
            for (int i = 0; i < 8; i++) begin
                if (strb_q[i]) begin
                    mem_q[addr_index(addr_q)][8*i +: 8] <= data_q[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_wr_slave_mem.sv
// Directed bench for axi_wr_slave_mem: a vector table of single writes plus
// hand sequences for split channels, BREADY back-pressure and reset mid-write.
module tb_axi_wr_slave_mem;

    logic        ACLK;
    logic        ARESET;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] AWADDR;
    logic        WVALID;
    logic        WREADY;
    logic [63:0] WDATA;
    logic [7:0]  WSTRB;
    logic        WLAST;
    logic        BVALID;
    logic        BREADY;
    logic [1:0]  BRESP;
    logic [31:0] dbg_addr;
    logic [63:0] dbg_rdata;

    int n_checks = 0;
    int n_err    = 0;

    axi_wr_slave_mem #(
        .BASE    (32'h8000_0000),
        .DEPTH   (1024),
        .LATENCY (2)
    ) dut (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .AWVALID   (AWVALID),
        .AWREADY   (AWREADY),
        .AWADDR    (AWADDR),
        .WVALID    (WVALID),
        .WREADY    (WREADY),
        .WDATA     (WDATA),
        .WSTRB     (WSTRB),
        .WLAST     (WLAST),
        .BVALID    (BVALID),
        .BREADY    (BREADY),
        .BRESP     (BRESP),
        .dbg_addr  (dbg_addr),
        .dbg_rdata (dbg_rdata)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [31:0] addr;
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
        logic [1:0]  exp_resp;
        logic [31:0] chk_addr;
        logic [63:0] exp_word;
    } vec_t;

    localparam int NVEC = 10;
    localparam int EXP_LAT = 3;  // edges from handshake to BVALID: 1 + LATENCY
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic issue_both(input logic [31:0] a, input logic [63:0] d,
                              input logic [7:0] s, input logic l);
        AWVALID = 1'b1; AWADDR = a;
        WVALID  = 1'b1; WDATA = d; WSTRB = s; WLAST = l;
        chk("ready_idle", {62'd0, AWREADY, WREADY}, 64'd3);
        tick();
        AWVALID = 1'b0;
        WVALID  = 1'b0;
    endtask

    task automatic wait_b(output int lat);
        lat = 0;
        while (BVALID !== 1'b1 && lat < 50) begin
            tick();
            lat++;
        end
    endtask

    task automatic release_b();
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
        chk("idle_after_b", {61'd0, AWREADY, WREADY, BVALID}, 64'd6);
    endtask

    task automatic read_word(input logic [31:0] a, output logic [63:0] w);
        dbg_addr = a;
        #1;
        w = dbg_rdata;
    endtask

    initial begin
        int lat;
        logic [63:0] w;
        logic saw_b;

        vecs[0] = '{32'h8000_0008, 64'h1122334455667788, 8'hFF, 1'b1, 2'b00, 32'h8000_0008, 64'h1122334455667788};
        vecs[1] = '{32'h8000_0008, 64'hFFFFFFFF_DEADBEEF, 8'h0F, 1'b1, 2'b00, 32'h8000_0008, 64'h11223344_DEADBEEF};
        vecs[2] = '{32'h8000_000D, 64'hAAAAAAAA_AAAAAAAA, 8'h00, 1'b1, 2'b00, 32'h8000_0008, 64'h11223344_DEADBEEF};
        vecs[3] = '{32'h8000_1FF8, 64'h0123456789ABCDEF, 8'hFF, 1'b1, 2'b00, 32'h8000_1FF8, 64'h0123456789ABCDEF};
        vecs[4] = '{32'h8000_2000, 64'h5A5A5A5A_5A5A5A5A, 8'hFF, 1'b1, 2'b11, 32'h8000_2000, 64'h0};
        vecs[5] = '{32'h7000_0000, 64'h5A5A5A5A_5A5A5A5A, 8'hFF, 1'b1, 2'b11, 32'h8000_0008, 64'h11223344_DEADBEEF};
        vecs[6] = '{32'h8000_0008, 64'h55555555_55555555, 8'hFF, 1'b0, 2'b10, 32'h8000_0008, 64'h11223344_DEADBEEF};
        vecs[7] = '{32'h7FFF_FFF8, 64'h66666666_66666666, 8'hFF, 1'b1, 2'b11, 32'h7FFF_FFF8, 64'h0};
        vecs[8] = '{32'h8000_1FF8, 64'hA1A2A3A4A5A6A7A8, 8'hA5, 1'b1, 2'b00, 32'h8000_1FF8, 64'hA123A36789A6CDA8};
        vecs[9] = '{32'h9000_0000, 64'h77777777_77777777, 8'hFF, 1'b0, 2'b11, 32'h8000_1FF8, 64'hA123A36789A6CDA8};

        ARESET = 1'b1; AWVALID = 1'b0; AWADDR = 32'd0; WVALID = 1'b0;
        WDATA = 64'd0; WSTRB = 8'd0; WLAST = 1'b0; BREADY = 1'b0; dbg_addr = 32'd0;

        // reset held for two cycles
        tick();
        chk("reset_outs_c1", {60'd0, AWREADY, WREADY, BVALID, 1'b0}, 64'd0);
        tick();
        chk("reset_outs_c2", {60'd0, AWREADY, WREADY, BVALID, 1'b0}, 64'd0);
        chk("reset_bresp", {62'd0, BRESP}, 64'd0);
        ARESET = 1'b0;
        #1;
        chk("ready_after_reset", {62'd0, AWREADY, WREADY}, 64'd3);

        for (int i = 0; i < NVEC; i++) begin
            issue_both(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].last);
            wait_b(lat);
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(EXP_LAT));
            chk($sformatf("vec%0d_bresp", i), {62'd0, BRESP}, {62'd0, vecs[i].exp_resp});
            release_b();
            read_word(vecs[i].chk_addr, w);
            chk($sformatf("vec%0d_word", i), w, vecs[i].exp_word);
        end

        // W first, AW three cycles later
        WVALID = 1'b1; WDATA = 64'h0F0E0D0C0B0A0908; WSTRB = 8'hFF; WLAST = 1'b1;
        tick();
        WVALID = 1'b0;
        chk("split_wready_c1", {62'd0, WREADY, AWREADY}, 64'd1);
        tick();
        chk("split_wready_c2", {62'd0, WREADY, AWREADY}, 64'd1);
        tick();
        chk("split_wready_c3", {62'd0, WREADY, AWREADY}, 64'd1);
        AWVALID = 1'b1; AWADDR = 32'h8000_0018;
        tick();
        AWVALID = 1'b0;
        wait_b(lat);
        chk("split_latency", 64'(lat), 64'(EXP_LAT));
        chk("split_bresp", {62'd0, BRESP}, 64'd0);
        release_b();
        read_word(32'h8000_0018, w);
        chk("split_word", w, 64'h0F0E0D0C0B0A0908);

        // BREADY held low in RESP
        issue_both(32'h8000_0020, 64'hCAFEF00D_12345678, 8'hFF, 1'b1);
        wait_b(lat);
        chk("bp_latency", 64'(lat), 64'(EXP_LAT));
        for (int c = 0; c < 5; c++) begin
            AWVALID = 1'b1; WVALID = 1'b1;
            AWADDR = 32'h8000_0030; WDATA = 64'h0; WSTRB = 8'hFF; WLAST = 1'b1;
            tick();
            chk($sformatf("bp_hold%0d", c), {60'd0, BVALID, AWREADY, WREADY, 1'b0}, 64'd8);
            chk($sformatf("bp_bresp%0d", c), {62'd0, BRESP}, 64'd0);
        end
        AWVALID = 1'b0; WVALID = 1'b0;
        release_b();
        read_word(32'h8000_0020, w);
        chk("bp_word", w, 64'hCAFEF00D_12345678);
        read_word(32'h8000_0030, w);
        chk("bp_no_extra_write", w == 64'h0 ? 64'd0 : 64'd1, 64'd0);

        // reset pulse while waiting to commit
        issue_both(32'h8000_0008, 64'h99999999_99999999, 8'hFF, 1'b1);
        tick();
        ARESET = 1'b1;
        #1;
        chk("rst_wait_outs", {61'd0, AWREADY, WREADY, BVALID}, 64'd0);
        tick();
        ARESET = 1'b0;
        #1;
        chk("rst_wait_idle", {61'd0, AWREADY, WREADY, BVALID}, 64'd6);
        saw_b = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (BVALID === 1'b1) saw_b = 1'b1;
        end
        chk("rst_wait_no_b", {63'd0, saw_b}, 64'd0);
        read_word(32'h8000_0008, w);
        chk("rst_wait_word", w, 64'h11223344_DEADBEEF);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
